vram_scanout: RTL

//  Read side of the VRAM frame buffer; cpusnoop is the write side. Generates 640x480@60 VGA

---
 rtl/vram_scanout_if.sv | 21 ++
 rtl/vram_scanout.sv | 82 ++++++++
 2 files changed

// File: rtl/vram_scanout_if.sv
// vram_scanout_if: VRAM read port, buffer select, seq export and VGA outputs of the scanout block
interface vram_scanout_if;
  logic        vidBufSel;
  logic [7:0]  vramDataIn;
  logic [14:0] vramAddr;
  logic        nvramOE;
  logic        nvramCE0;
  logic        nvramCE1;
  logic [2:0]  seq;
  logic        hSync;
  logic        vSync;
  logic        pixOut;
  modport master (
    input  vidBufSel, vramDataIn,
    output vramAddr, nvramOE, nvramCE0, nvramCE1, seq, hSync, vSync, pixOut
  );
  modport slave (
    output vidBufSel, vramDataIn,
    input  vramAddr, nvramOE, nvramCE0, nvramCE1, seq, hSync, vSync, pixOut
  );
endinterface

// File: rtl/vram_scanout.sv
// vram_scanout: 640x480 VGA timing, one VRAM fetch per 8-pixel cell and MSB-first shifter for the centred SE image
module vram_scanout #(
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 752,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 492,
  parameter int H_OFFSET     = 64,
  parameter int V_OFFSET     = 69,
  parameter int LINE_BYTES   = 64,
  parameter int SE_LINES     = 342
) (
  input logic            pixClock,
  input logic            reset,
  vram_scanout_if.master bus
);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS0    = 10'(H_SYNC_START);
  localparam logic [9:0] HS1    = 10'(H_SYNC_END);
  localparam logic [9:0] VS0    = 10'(V_SYNC_START);
  localparam logic [9:0] VS1    = 10'(V_SYNC_END);
  localparam logic [9:0] HW0    = 10'(H_OFFSET);
  localparam logic [9:0] HW1    = 10'(H_OFFSET + 8 * LINE_BYTES);
  localparam logic [9:0] VW0    = 10'(V_OFFSET);
  localparam logic [9:0] VW1    = 10'(V_OFFSET + SE_LINES);
  // fetch runs one cell ahead of the displayed cell
  localparam logic [6:0] C0     = 7'(H_OFFSET / 8 - 1);
  localparam logic [6:0] C1     = 7'(H_OFFSET / 8 + LINE_BYTES - 2);
  logic [9:0]  h_q, h_d, v_q, v_d;
  logic [14:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d, shift_q, shift_d;
  logic        buf_q, buf_d, hs_q, hs_d, vs_q, vs_d, pix_q, pix_d;
  logic        frame_start, fetch_cell, rd, load;
  always_comb begin
    frame_start = h_q == '0 && v_q == '0;
    h_d         = h_q == H_LAST ? '0 : h_q + 10'd1;
    v_d         = h_q != H_LAST ? v_q : v_q == V_LAST ? '0 : v_q + 10'd1;
    fetch_cell  = v_q >= VW0 && v_q < VW1 && h_q[9:3] >= C0 && h_q[9:3] <= C1;
    rd          = fetch_cell && h_q[2:0] == 3'd0;
    load        = fetch_cell && h_q[2:0] == 3'd7;
    addr_d      = frame_start ? '0 : rd ? addr_q + 15'd1 : addr_q;
    data_d      = rd ? bus.vramDataIn : data_q;
    shift_d     = load ? data_q : {shift_q[6:0], 1'b0};
    buf_d       = frame_start ? bus.vidBufSel : buf_q;
    hs_d        = !(h_q >= HS0 && h_q < HS1);
    vs_d        = !(v_q >= VS0 && v_q < VS1);
    pix_d       = v_q >= VW0 && v_q < VW1 && h_q >= HW0 && h_q < HW1 && !shift_q[7];
  end
  always_ff @(posedge pixClock) begin
    if (reset) begin
      h_q     <= '0;
      v_q     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      shift_q <= '0;
      buf_q   <= 1'b1;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      pix_q   <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      shift_q <= shift_d;
      buf_q   <= buf_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      pix_q   <= pix_d;
    end
  end
  assign bus.seq      = h_q[2:0];
  assign bus.vramAddr = addr_q;
  assign bus.nvramOE  = !rd;
  assign bus.nvramCE0 = !(rd && buf_q);
  assign bus.nvramCE1 = !(rd && !buf_q);
  assign bus.hSync    = hs_q;
  assign bus.vSync    = vs_q;
  assign bus.pixOut   = pix_q;
endmodule
